// File: rtl/cpu15_ctrl_core.sv
// ---------------------------------------------------------------------------
// cpu15_ctrl_core
//
// Control and execute core of the CPU15 processor. It contains:
//   - a one-hot four-phase sequencer (fetch / decode / execute / write-back)
//     whose strobes act as clock enables for the rest of the CPU,
//   - the instruction decode latch (opcode and data/address field),
//   - the execute unit: program counter, ALU, compare flag and the register
//     and RAM write-enable generation.
//
// Ports:
//   CLK       in   system clock, all state changes on its rising edge
//   RESET_N   in   asynchronous active-low reset
//   PROM_OUT  in   [14:0] instruction word: [14:11] opcode, [10:8] reg A,
//                  [7:5] reg B, [7:0] data/address
//   REG_A     in   [15:0] register A value from the external decode stage
//   REG_B     in   [15:0] register B value
//   RAM_OUT   in   [15:0] RAM/IO word at address OP_DATA
//   CLK_FT    out  fetch phase strobe
//   CLK_DC    out  decode phase strobe
//   CLK_EX    out  execute phase strobe
//   CLK_WB    out  write-back phase strobe
//   OP_CODE   out  [3:0] latched opcode
//   OP_DATA   out  [7:0] latched data/address field
//   P_COUNT   out  [7:0] program counter (ROM address)
//   REG_IN    out  [15:0] register write-back data
//   RAM_IN    out  [15:0] RAM write data
//   REG_WEN   out  register write enable
//   RAM_WEN   out  RAM write enable
//
// Build option:
//   CPU15_HLT_EN  when defined, opcode 15 (hlt) freezes the program counter
//                 so the same word is fetched again until reset. When not
//                 defined, opcode 15 behaves as a plain no-op.
// ---------------------------------------------------------------------------
module cpu15_ctrl_core (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [14:0] PROM_OUT,
  input  logic [15:0] REG_A,
  input  logic [15:0] REG_B,
  input  logic [15:0] RAM_OUT,
  output logic        CLK_FT,
  output logic        CLK_DC,
  output logic        CLK_EX,
  output logic        CLK_WB,
  output logic [3:0]  OP_CODE,
  output logic [7:0]  OP_DATA,
  output logic [7:0]  P_COUNT,
  output logic [15:0] REG_IN,
  output logic [15:0] RAM_IN,
  output logic        REG_WEN,
  output logic        RAM_WEN
);

  // One-hot phase encoding, so each strobe is simply one state bit.
  typedef enum logic [3:0] {
    PH_FT = 4'b0001,
    PH_DC = 4'b0010,
    PH_EX = 4'b0100,
    PH_WB = 4'b1000
  } phase_t;

  phase_t phase;
  phase_t phase_next;

  // Compare flag, written only by cmp and read only by je.
  logic        flag;

  // Next values for the execute registers, computed from the latched opcode.
  logic [7:0]  pc_next;
  logic [15:0] reg_in_next;
  logic [15:0] ram_in_next;
  logic        reg_wen_next;
  logic        ram_wen_next;
  logic        flag_next;

  // The register-select fields are consumed by the external decode stage,
  // not here.
  logic unused_reg_sel;
  assign unused_reg_sel = ^PROM_OUT[10:8];

  // Sequencer state register. Reset parks the ring in fetch, so the first
  // edge after release moves into decode.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase <= PH_FT;
    end else begin
      phase <= phase_next;
    end
  end

  // Sequencer next-state logic: a plain ring FT -> DC -> EX -> WB -> FT.
  // The default arm recovers to fetch should the register ever be corrupted.
  always_comb begin
    phase_next = PH_FT;
    case (phase)
      PH_FT:   phase_next = PH_DC;
      PH_DC:   phase_next = PH_EX;
      PH_EX:   phase_next = PH_WB;
      PH_WB:   phase_next = PH_FT;
      default: phase_next = PH_FT;
    endcase
  end

  // Sequencer outputs: the strobes are the one-hot state bits.
  always_comb begin
    CLK_FT = (phase == PH_FT);
    CLK_DC = (phase == PH_DC);
    CLK_EX = (phase == PH_EX);
    CLK_WB = (phase == PH_WB);
  end

  // Decode latch: capture opcode and data field at the decode edge. The ROM
  // address has been stable since the previous write-back phase.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OP_CODE <= 4'd0;
      OP_DATA <= 8'd0;
    end else if (phase == PH_DC) begin
      OP_CODE <= PROM_OUT[14:11];
      OP_DATA <= PROM_OUT[7:0];
    end
  end

  // Execute datapath. By default the PC advances, nothing is written and the
  // data outputs keep their previous values; each opcode overrides only what
  // it changes.
  always_comb begin
    pc_next      = P_COUNT + 8'd1;
    reg_in_next  = REG_IN;
    ram_in_next  = RAM_IN;
    reg_wen_next = 1'b0;
    ram_wen_next = 1'b0;
    flag_next    = flag;
    case (OP_CODE)
      4'd0: begin
        reg_in_next  = REG_B;
        reg_wen_next = 1'b1;
      end
      4'd1: begin
        reg_in_next  = REG_A + REG_B;
        reg_wen_next = 1'b1;
      end
      4'd2: begin
        reg_in_next  = REG_A - REG_B;
        reg_wen_next = 1'b1;
      end
      4'd3: begin
        reg_in_next  = REG_A & REG_B;
        reg_wen_next = 1'b1;
      end
      4'd4: begin
        reg_in_next  = REG_A | REG_B;
        reg_wen_next = 1'b1;
      end
      4'd5: begin
        reg_in_next  = {REG_A[14:0], 1'b0};
        reg_wen_next = 1'b1;
      end
      4'd6: begin
        reg_in_next  = {1'b0, REG_A[15:1]};
        reg_wen_next = 1'b1;
      end
      4'd7: begin
        reg_in_next  = {REG_A[15], REG_A[15:1]};
        reg_wen_next = 1'b1;
      end
      4'd8: begin
        reg_in_next  = {REG_A[15:8], OP_DATA};
        reg_wen_next = 1'b1;
      end
      4'd9: begin
        reg_in_next  = {OP_DATA, REG_A[7:0]};
        reg_wen_next = 1'b1;
      end
      4'd10: begin
        flag_next = (REG_A == REG_B);
      end
      4'd11: begin
        if (flag) begin
          pc_next = OP_DATA;
        end
      end
      4'd12: begin
        pc_next = OP_DATA;
      end
      4'd13: begin
        reg_in_next  = RAM_OUT;
        reg_wen_next = 1'b1;
      end
      4'd14: begin
        ram_in_next  = REG_A;
        ram_wen_next = 1'b1;
      end
      4'd15: begin
`ifdef CPU15_HLT_EN
        // Holding the PC makes the ROM keep presenting the hlt word.
        pc_next = P_COUNT;
`else
        pc_next = P_COUNT + 8'd1;
`endif
      end
      default: begin
        pc_next = P_COUNT + 8'd1;
      end
    endcase
  end

  // Execute registers update only on the execute edge, so their values are
  // stable through write-back and hold until the next instruction executes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      P_COUNT <= 8'd0;
      REG_IN  <= 16'd0;
      RAM_IN  <= 16'd0;
      REG_WEN <= 1'b0;
      RAM_WEN <= 1'b0;
      flag    <= 1'b0;
    end else if (phase == PH_EX) begin
      P_COUNT <= pc_next;
      REG_IN  <= reg_in_next;
      RAM_IN  <= ram_in_next;
      REG_WEN <= reg_wen_next;
      RAM_WEN <= ram_wen_next;
      flag    <= flag_next;
    end
  end

endmodule

// File: tb/tb_cpu15_ctrl_core.sv
// ---------------------------------------------------------------------------
// tb_cpu15_ctrl_core
//
// Directed bench for cpu15_ctrl_core. Each instruction is presented while the
// core is in fetch, then the bench steps to the write-back phase and compares
// the execute outputs against hand-computed values.
// Honours CPU15_HLT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_cpu15_ctrl_core;

  logic        CLK;
  logic        RESET_N;
  logic [14:0] PROM_OUT;
  logic [15:0] REG_A;
  logic [15:0] REG_B;
  logic [15:0] RAM_OUT;
  logic        CLK_FT;
  logic        CLK_DC;
  logic        CLK_EX;
  logic        CLK_WB;
  logic [3:0]  OP_CODE;
  logic [7:0]  OP_DATA;
  logic [7:0]  P_COUNT;
  logic [15:0] REG_IN;
  logic [15:0] RAM_IN;
  logic        REG_WEN;
  logic        RAM_WEN;

  int checkCount = 0;
  int passCount  = 0;

  cpu15_ctrl_core dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .PROM_OUT (PROM_OUT),
    .REG_A    (REG_A),
    .REG_B    (REG_B),
    .RAM_OUT  (RAM_OUT),
    .CLK_FT   (CLK_FT),
    .CLK_DC   (CLK_DC),
    .CLK_EX   (CLK_EX),
    .CLK_WB   (CLK_WB),
    .OP_CODE  (OP_CODE),
    .OP_DATA  (OP_DATA),
    .P_COUNT  (P_COUNT),
    .REG_IN   (REG_IN),
    .RAM_IN   (RAM_IN),
    .REG_WEN  (REG_WEN),
    .RAM_WEN  (RAM_WEN)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Step until the fetch phase (bounded), sampling 1 unit after each edge.
  task automatic syncToFetch();
    int guard = 0;
    while (!CLK_FT && guard < 8) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    checkOutput("sync_ft", {31'd0, CLK_FT}, 32'd1);
  endtask

  // Present one instruction during fetch and advance to its write-back phase.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] data,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] ram);
    syncToFetch();
    PROM_OUT = {op, 3'd0, data};
    REG_A    = a;
    REG_B    = b;
    RAM_OUT  = ram;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // Compare the write-back outputs of the instruction just executed.
  task automatic checkExec(input string tag, input logic [7:0] pc,
                           input logic [15:0] regIn, input logic regWen,
                           input logic ramWen);
    checkOutput({tag, "_pc"},   {24'd0, P_COUNT}, {24'd0, pc});
    checkOutput({tag, "_reg"},  {16'd0, REG_IN},  {16'd0, regIn});
    checkOutput({tag, "_rwen"}, {31'd0, REG_WEN}, {31'd0, regWen});
    checkOutput({tag, "_mwen"}, {31'd0, RAM_WEN}, {31'd0, ramWen});
  endtask

  initial begin
    logic [3:0] phaseExp [8];
    logic [7:0] pcExp    [8];
    phaseExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    pcExp    = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};

    RESET_N  = 1'b0;
    PROM_OUT = 15'd0;
    REG_A    = 16'd0;
    REG_B    = 16'd0;
    RAM_OUT  = 16'd0;

    // Reset values while held in reset across a couple of edges.
    #12;
    checkOutput("rst_phase", {28'd0, CLK_WB, CLK_EX, CLK_DC, CLK_FT}, 32'h1);
    checkOutput("rst_pc",    {24'd0, P_COUNT}, 32'h0);
    checkOutput("rst_regin", {16'd0, REG_IN},  32'h0);
    checkOutput("rst_ramin", {16'd0, RAM_IN},  32'h0);
    checkOutput("rst_op",    {20'd0, OP_CODE, OP_DATA}, 32'h0);
    checkOutput("rst_wen",   {30'd0, REG_WEN, RAM_WEN}, 32'h0);

    // Release and watch the ring for two instructions of mov B=0.
    #1 RESET_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("ring_phase%0d", i),
                  {28'd0, CLK_WB, CLK_EX, CLK_DC, CLK_FT}, {28'd0, phaseExp[i]});
      checkOutput($sformatf("ring_pc%0d", i), {24'd0, P_COUNT}, {24'd0, pcExp[i]});
      @(posedge CLK);
      #1;
    end

    // Load low / load high.
    applyStimulus(4'd8, 8'h34, 16'h1200, 16'h0000, 16'h0000);
    checkExec("ldl", 8'd3, 16'h1234, 1'b1, 1'b0);
    checkOutput("ldl_opcode", {28'd0, OP_CODE}, 32'd8);
    checkOutput("ldl_opdata", {24'd0, OP_DATA}, 32'h34);
    applyStimulus(4'd9, 8'hAB, 16'h1234, 16'h0000, 16'h0000);
    checkExec("ldh", 8'd4, 16'hAB34, 1'b1, 1'b0);

    // ALU operations.
    applyStimulus(4'd1, 8'h00, 16'hFFFF, 16'h0002, 16'h0000);
    checkExec("add", 8'd5, 16'h0001, 1'b1, 1'b0);
    applyStimulus(4'd2, 8'h00, 16'h0000, 16'h0001, 16'h0000);
    checkExec("sub", 8'd6, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(4'd7, 8'h00, 16'h8004, 16'h0000, 16'h0000);
    checkExec("sra", 8'd7, 16'hC002, 1'b1, 1'b0);
    applyStimulus(4'd6, 8'h00, 16'h8004, 16'h0000, 16'h0000);
    checkExec("sr", 8'd8, 16'h4002, 1'b1, 1'b0);
    applyStimulus(4'd0, 8'h00, 16'h1111, 16'h0BEE, 16'h0000);
    checkExec("mov", 8'd9, 16'h0BEE, 1'b1, 1'b0);
    applyStimulus(4'd3, 8'h00, 16'hF0F0, 16'h3C3C, 16'h0000);
    checkExec("and", 8'd10, 16'h3030, 1'b1, 1'b0);
    applyStimulus(4'd4, 8'h00, 16'hF0F0, 16'h3C3C, 16'h0000);
    checkExec("or", 8'd11, 16'hFCFC, 1'b1, 1'b0);
    applyStimulus(4'd5, 8'h00, 16'h8001, 16'h0000, 16'h0000);
    checkExec("sl", 8'd12, 16'h0002, 1'b1, 1'b0);

    // Compare and branch; REG_IN holds its last value.
    applyStimulus(4'd10, 8'h00, 16'd5, 16'd5, 16'h0000);
    checkExec("cmp_eq", 8'd13, 16'h0002, 1'b0, 1'b0);
    applyStimulus(4'd11, 8'h10, 16'd0, 16'd0, 16'h0000);
    checkExec("je_taken", 8'h10, 16'h0002, 1'b0, 1'b0);
    applyStimulus(4'd10, 8'h00, 16'd5, 16'd6, 16'h0000);
    checkExec("cmp_ne", 8'h11, 16'h0002, 1'b0, 1'b0);
    applyStimulus(4'd11, 8'h10, 16'd0, 16'd0, 16'h0000);
    checkExec("je_not", 8'h12, 16'h0002, 1'b0, 1'b0);
    applyStimulus(4'd12, 8'hFF, 16'd0, 16'd0, 16'h0000);
    checkExec("jmp", 8'hFF, 16'h0002, 1'b0, 1'b0);
    applyStimulus(4'd0, 8'h00, 16'd0, 16'h0001, 16'h0000);
    checkExec("wrap", 8'h00, 16'h0001, 1'b1, 1'b0);

    // Store then load.
    applyStimulus(4'd14, 8'h40, 16'h5A5A, 16'h0000, 16'h0000);
    checkExec("st", 8'd1, 16'h0001, 1'b0, 1'b1);
    checkOutput("st_ramin",  {16'd0, RAM_IN},  32'h5A5A);
    checkOutput("st_opdata", {24'd0, OP_DATA}, 32'h40);
    applyStimulus(4'd13, 8'h40, 16'h0000, 16'h0000, 16'h1357);
    checkExec("ld", 8'd2, 16'h1357, 1'b1, 1'b0);
    checkOutput("ld_ramin", {16'd0, RAM_IN}, 32'h5A5A);

    // Reach PC=3, then halt.
    applyStimulus(4'd0, 8'h00, 16'h0000, 16'h0042, 16'h0000);
    checkExec("pre_hlt", 8'd3, 16'h0042, 1'b1, 1'b0);
`ifdef CPU15_HLT_EN
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'd15, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    end
    checkExec("hlt", 8'd3, 16'h0042, 1'b0, 1'b0);
`else
    applyStimulus(4'd15, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    checkExec("hlt_nop", 8'd4, 16'h0042, 1'b0, 1'b0);
`endif

    // Set the flag, then pulse reset in the middle of an execute cycle.
    applyStimulus(4'd10, 8'h00, 16'd9, 16'd9, 16'h0000);
    applyStimulus(4'd14, 8'h00, 16'h7777, 16'h0000, 16'h0000);
    syncToFetch();
    PROM_OUT = {4'd0, 3'd0, 8'h99};
    REG_B    = 16'hBEEF;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    checkOutput("pre_rst_ex", {31'd0, CLK_EX}, 32'd1);
    RESET_N = 1'b0;
    #1;
    checkOutput("mid_rst_phase", {28'd0, CLK_WB, CLK_EX, CLK_DC, CLK_FT}, 32'h1);
    checkOutput("mid_rst_pc",    {24'd0, P_COUNT}, 32'h0);
    checkOutput("mid_rst_ramin", {16'd0, RAM_IN},  32'h0);
    checkOutput("mid_rst_op",    {20'd0, OP_CODE, OP_DATA}, 32'h0);
    checkOutput("mid_rst_wen",   {30'd0, REG_WEN, RAM_WEN}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Flag was cleared by reset, so je must fall through.
    applyStimulus(4'd11, 8'h20, 16'd0, 16'd0, 16'h0000);
    checkExec("je_after_rst", 8'd1, 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
